booth4_seq_mult: RTL and testbench

//  Sequential radix-4 (modified Booth) multiplier: one Booth digit (partial product) per cycle,

---
 rtl/booth4_seq_mult.sv | 142 ++++++++++++++
 tb/tb_booth4_seq_mult.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/booth4_seq_mult.sv
// Sequential radix-4 (modified Booth) multiplier.
// One Booth digit is retired per clock into a 2*TAM-bit accumulator; signed or
// unsigned operation is chosen per transaction. Valid/ready on both sides,
// one multiplication in flight at a time, fixed latency of NDIG CALC cycles.
module booth4_seq_mult #(
    parameter int TAM = 16   // operand width; must be even and >= 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAM-1:0]   A,
    input  logic [TAM-1:0]   B,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*TAM-1:0] S,
    output logic             busy
);

    // Booth digits per operation; the two extra extension bits of MR make the
    // top digit cover the unsigned case as well.
    localparam int NDIG = (TAM + 2) / 2;
    localparam int PW   = 2 * TAM;          // product width
    localparam int MW   = TAM + 3;          // multiplier register width
    localparam int CW   = $clog2(NDIG + 1); // digit counter width
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] md_q, md_d;    // multiplicand, pre-shifted by 2k for digit k
    logic [MW-1:0] mr_q, mr_d;    // multiplier, shifted right 2 per digit
    logic [PW-1:0] p_q, p_d;      // running partial sum
    logic [PW-1:0] s_q, s_d;      // published product
    logic [CW-1:0] cnt_q, cnt_d;  // digits processed so far
    logic [PW-1:0] pp;            // selected partial product for this digit
    logic          accept;
    logic          last_digit;
    logic          ext;

    assign accept     = (state_q == IDLE) && in_valid;
    assign last_digit = (state_q == CALC) && (cnt_q == LAST_CNT);
    assign ext        = sgn & B[TAM-1];

    // State register: asynchronous reset back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> CALC on accept, CALC -> DONE after the last
    // digit, DONE -> IDLE once the consumer takes the result.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)   state_d = CALC;
            CALC: if (last_digit) state_d = DONE;
            DONE: if (out_ready)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            CALC: busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Booth recoding of the current triplet (low three bits of the shifted MR).
    always_comb begin
        pp = '0;
        unique case (mr_q[2:0])
            3'b001, 3'b010: pp = md_q;
            3'b011:         pp = md_q << 1;
            3'b100:         pp = -(md_q << 1);
            3'b101, 3'b110: pp = -md_q;
            default:        pp = '0;
        endcase
    end

    // Datapath next values: latch operands on accept, accumulate one digit
    // per CALC cycle, and publish the product on the DONE-entry edge.
    always_comb begin
        md_d  = md_q;
        mr_d  = mr_q;
        p_d   = p_q;
        s_d   = s_q;
        cnt_d = cnt_q;
        if (accept) begin
            md_d  = sgn ? {{TAM{A[TAM-1]}}, A} : {{TAM{1'b0}}, A};
            mr_d  = {ext, ext, B, 1'b0};
            p_d   = '0;
            cnt_d = '0;
        end else if (state_q == CALC) begin
            p_d   = p_q + pp;
            md_d  = md_q << 2;
            mr_d  = {2'b00, mr_q[MW-1:2]};
            cnt_d = cnt_q + CW'(1);
            if (last_digit) begin
                s_d = p_q + pp;
            end
        end
    end

    // Datapath registers: reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_q  <= '0;
            mr_q  <= '0;
            p_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
        end else begin
            md_q  <= md_d;
            mr_q  <= mr_d;
            p_q   <= p_d;
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign S = s_q;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Bench for booth4_seq_mult at TAM=8: directed corner products, back-pressure,
// asynchronous reset mid-operation and randomized traffic against an
// arithmetic reference product.
module tb_booth4_seq_mult;

    localparam int TAM  = 8;
    localparam int NDIG = (TAM + 2) / 2;
    localparam int NRAND = 4000;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [TAM-1:0]   A         = '0;
    logic [TAM-1:0]   B         = '0;
    logic             sgn       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*TAM-1:0] S;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    booth4_seq_mult #(.TAM(TAM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product, reduced to the 2*TAM-bit result.
    function automatic logic [2*TAM-1:0] ref_mul(input logic [TAM-1:0] a,
                                                 input logic [TAM-1:0] b,
                                                 input logic s);
        longint ia;
        longint ib;
        longint prod;
        ia = s ? longint'($signed(a)) : longint'({56'd0, a});
        ib = s ? longint'($signed(b)) : longint'({56'd0, b});
        prod = ia * ib;
        return prod[2*TAM-1:0];
    endfunction

    // Drives one transaction; must be entered just after a falling edge with
    // the DUT idle, and returns just after a falling edge with the DUT idle.
    task automatic run_op(input logic [TAM-1:0] a, input logic [TAM-1:0] b,
                          input logic s, input int hold, input bit noise,
                          output logic [2*TAM-1:0] res, output int lat,
                          output bit accept_ok, output int bad_ready,
                          output int s_moved, output bit drop_ok);
        accept_ok = (in_ready === 1'b1) && (busy === 1'b0) && (out_valid === 1'b0);
        A = a; B = b; sgn = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 0; bad_ready = 0; s_moved = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 4 * NDIG) begin
            if (in_ready !== 1'b0) bad_ready++;
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                A         = TAM'($urandom);
                B         = TAM'($urandom);
                sgn       = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = S;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (S !== res || out_valid !== 1'b1) s_moved++;
            if (in_ready !== 1'b0) bad_ready++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drop_ok = (out_valid === 1'b0) && (in_ready === 1'b1) && (busy === 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #20;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (S !== '0)           begin n_errors++; $display("FAIL reset_S: got %h expected 0000", S); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: out_valid=%b in_ready=%b busy=%b S=%h", out_valid, in_ready, busy, S);
    endtask

    task automatic test_directed;
        logic [TAM-1:0]   ta [6] = '{8'h00, 8'hFD, 8'hFF, 8'hFF, 8'h80, 8'h80};
        logic [TAM-1:0]   tb [6] = '{8'h5A, 8'h05, 8'hFF, 8'hFF, 8'h80, 8'h7F};
        logic             ts [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
        logic [2*TAM-1:0] te [6] = '{16'h0000, 16'hFFF1, 16'hFE01, 16'h0001, 16'h4000, 16'hC080};
        logic [2*TAM-1:0] res;
        int lat, bad_ready, s_moved;
        bit accept_ok, drop_ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], ts[i], 0, 1'b0, res, lat, accept_ok, bad_ready, s_moved, drop_ok);
            $display("directed: a=%h b=%h sgn=%0d S=%h lat=%0d", ta[i], tb[i], ts[i], res, lat);
            n_checks++; if (res !== te[i]) begin n_errors++; $display("FAIL directed_S[%0d]: got %h expected %h", i, res, te[i]); end
            n_checks++; if (lat != NDIG) begin n_errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, NDIG); end
            n_checks++; if (!accept_ok || !drop_ok || bad_ready != 0) begin
                n_errors++;
                $display("FAIL directed_handshake[%0d]: got accept=%0d drop=%0d bad_ready=%0d expected 1 1 0", i, accept_ok, drop_ok, bad_ready);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [2*TAM-1:0] res;
        logic [2*TAM-1:0] exp_s;
        int lat, bad_ready, s_moved;
        bit accept_ok, drop_ok;
        exp_s = ref_mul(8'h9C, 8'h3B, 1'b1);
        run_op(8'h9C, 8'h3B, 1'b1, 10, 1'b0, res, lat, accept_ok, bad_ready, s_moved, drop_ok);
        $display("backpressure: a=9c b=3b sgn=1 S=%h lat=%0d", res, lat);
        n_checks++; if (res !== exp_s) begin n_errors++; $display("FAIL bp_S: got %h expected %h", res, exp_s); end
        n_checks++; if (s_moved != 0)  begin n_errors++; $display("FAIL bp_stable: got %0d changed cycles expected 0", s_moved); end
        n_checks++; if (bad_ready != 0) begin n_errors++; $display("FAIL bp_in_ready: got %0d ready cycles while busy expected 0", bad_ready); end
        n_checks++; if (!drop_ok)      begin n_errors++; $display("FAIL bp_release: got drop=%0d expected 1", drop_ok); end
    endtask

    task automatic test_reset_mid;
        logic [2*TAM-1:0] res;
        int lat, bad_ready, s_moved, seen;
        bit accept_ok, drop_ok;
        A = 8'h35; B = 8'h6B; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || S !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got out_valid=%b in_ready=%b busy=%b S=%h expected 0 1 0 0000", out_valid, in_ready, busy, S);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < NDIG + 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_errors++; $display("FAIL midreset_no_valid: got %0d valid cycles expected 0", seen); end
        run_op(8'h07, 8'h06, 1'b0, 0, 1'b0, res, lat, accept_ok, bad_ready, s_moved, drop_ok);
        $display("after reset: a=07 b=06 sgn=0 S=%h lat=%0d", res, lat);
        n_checks++; if (res !== 16'h002A) begin n_errors++; $display("FAIL midreset_next_S: got %h expected 002a", res); end
        n_checks++; if (lat != NDIG)      begin n_errors++; $display("FAIL midreset_next_latency: got %0d expected %0d", lat, NDIG); end
    endtask

    task automatic test_random;
        logic [TAM-1:0]   a, b;
        logic             s;
        logic [2*TAM-1:0] res, exp_s;
        int lat, bad_ready, s_moved, hold;
        bit accept_ok, drop_ok;
        for (int n = 0; n < NRAND; n++) begin
            a = TAM'($urandom);
            b = TAM'($urandom);
            s = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            exp_s = ref_mul(a, b, s);
            run_op(a, b, s, hold, 1'b1, res, lat, accept_ok, bad_ready, s_moved, drop_ok);
            $display("random %0d: a=%h b=%h sgn=%0d S=%h lat=%0d", n, a, b, s, res, lat);
            n_checks++; if (res !== exp_s) begin n_errors++; $display("FAIL random_S[%0d]: got %h expected %h", n, res, exp_s); end
            n_checks++; if (lat != NDIG)   begin n_errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", n, lat, NDIG); end
            n_checks++; if (!accept_ok || bad_ready != 0 || s_moved != 0 || !drop_ok) begin
                n_errors++;
                $display("FAIL random_handshake[%0d]: got accept=%0d bad_ready=%0d s_moved=%0d drop=%0d expected 1 0 0 1",
                         n, accept_ok, bad_ready, s_moved, drop_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
